// File: rtl/data_cache.sv
// data_cache: direct-mapped, one-word-per-line, write-through / no-write-allocate data cache
// sitting in the memory stage of a pipeline.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   memreadM/memwriteM  load / store request (both high is a store)
//   aluresultM          byte address (bits [1:0] ignored)
//   writedataM          store data
//   flush               invalidate every line at the next edge
//   readdataM, stallM   load data and pipeline stall
//   mem_*               single-word backing-memory request/response handshake
//   hit_count/miss_count  saturating load hit/miss counters
module data_cache #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SETS       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memreadM,
    input  logic                  memwriteM,
    input  logic [DATA_WIDTH-1:0] aluresultM,
    input  logic [DATA_WIDTH-1:0] writedataM,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] readdataM,
    output logic                  stallM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned TW = DATA_WIDTH - 2 - IW;

    typedef enum logic [1:0] {StIdle, StReadMiss, StWriteThru} state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [SETS-1:0]         r_valid;
    logic [TW-1:0]           r_tag  [SETS];
    logic [DATA_WIDTH-1:0]   r_data [SETS];
    logic [DATA_WIDTH-3:0]   r_waddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [15:0]             r_hit_cnt;
    logic [15:0]             r_miss_cnt;

    logic [IW-1:0]           w_idx;
    logic [TW-1:0]           w_tag;
    logic [IW-1:0]           w_fill_idx;
    logic [TW-1:0]           w_fill_tag;
    logic                    w_hit;
    logic                    w_load;
    logic                    w_store;
    logic                    w_fill;
    logic                    w_idle;
    logic                    w_unused_lo;

    assign w_idx       = aluresultM[IW+1:2];
    assign w_tag       = aluresultM[DATA_WIDTH-1:IW+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_store     = memwriteM;
    assign w_load      = memreadM && !memwriteM;
    assign w_idle      = (r_state == StIdle);
    assign w_fill      = (r_state == StReadMiss) && mem_ready;
    assign w_fill_idx  = r_waddr[IW-1:0];
    assign w_fill_tag  = r_waddr[DATA_WIDTH-3:IW];
    assign w_unused_lo = ^aluresultM[1:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_store) begin
                    w_state_next = StWriteThru;
                end else if (w_load && !w_hit) begin
                    w_state_next = StReadMiss;
                end
            end
            StReadMiss, StWriteThru: begin
                if (mem_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs; reset overrides so the pipeline sees a quiet cache while rst is low
    always_comb begin
        stallM    = 1'b0;
        readdataM = '0;
        if (rst) begin
            unique case (r_state)
                StIdle: begin
                    if (w_store) begin
                        stallM = 1'b1;
                    end else if (w_load) begin
                        stallM = !w_hit;
                        if (w_hit) begin
                            readdataM = r_data[w_idx];
                        end
                    end
                end
                StReadMiss: begin
                    stallM = !mem_ready;
                    if (mem_ready) begin
                        readdataM = mem_rdata;
                    end
                end
                StWriteThru: stallM = !mem_ready;
                default: ;
            endcase
        end
    end

    // Backing-memory controls come straight from registers, so they hold for the whole request
    assign mem_req    = (r_state != StIdle);
    assign mem_we     = (r_state == StWriteThru);
    assign mem_addr   = {r_waddr, 2'b00};
    assign mem_wdata  = r_wdata;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    // Request latch: captured only when leaving IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_idle && (w_store || (w_load && !w_hit))) begin
            r_waddr <= aluresultM[DATA_WIDTH-1:2];
            if (w_store) begin
                r_wdata <= writedataM;
            end
        end
    end

    // Valid bits; the fill assignment comes last so a coincident fill survives a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            if (flush) begin
                r_valid <= '0;
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays need no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_rdata;
        end else if (w_idle && w_store && w_hit) begin
            r_data[w_idx] <= writedataM;
        end
    end

    // Saturating load statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_idle && w_load) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) begin
                    r_hit_cnt <= r_hit_cnt + 16'd1;
                end
            end else if (r_miss_cnt != 16'hFFFF) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache with a word-addressed backing memory
// model that answers each request in a programmable request cycle.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic        memreadM;
    logic        memwriteM;
    logic [31:0] aluresultM;
    logic [31:0] writedataM;
    logic        flush;
    logic [31:0] readdataM;
    logic        stallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    data_cache #(
        .DATA_WIDTH(32),
        .SETS      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .memreadM  (memreadM),
        .memwriteM (memwriteM),
        .aluresultM(aluresultM),
        .writedataM(writedataM),
        .flush     (flush),
        .readdataM (readdataM),
        .stallM    (stallM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: unwritten words read as a fixed pattern
    int          cur_lat;
    int          req_cyc;
    logic [31:0] bmem [256];
    logic [255:0] bwritten;
    logic [7:0]  widx;

    function automatic logic [31:0] init_word(input logic [7:0] i);
        if (i == 8'd64) return 32'hDEADBEEF;
        if (i == 8'd72) return 32'hCAFEF00D;
        return {24'hC00000, i};
    endfunction

    assign widx      = mem_addr[9:2];
    assign mem_ready = mem_req && (req_cyc == cur_lat - 1);
    assign mem_rdata = mem_ready ? (bwritten[widx] ? bmem[widx] : init_word(widx))
                                 : 32'h0BAD0BAD;

    initial req_cyc = 0;
    initial bwritten = '0;
    always @(posedge clk) begin
        if (!mem_req || mem_ready) req_cyc <= 0;
        else                       req_cyc <= req_cyc + 1;
        if (mem_req && mem_we && mem_ready) begin
            bmem[widx]     <= mem_wdata;
            bwritten[widx] <= 1'b1;
        end
    end

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    typedef struct {
        string       name;
        logic [31:0] data;
        int          stalls;
        bit          chk_data;
        bit          exp_req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t sbq[$];

    // op: 1 load, 2 store, 3 both (store)
    task automatic run_op(input string name, input int op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic [31:0] exp_data,
                          input int exp_stall, input bit flush_rdy);
        exp_t        e;
        int          stalls;
        bit          done;
        bit          seen;
        bit          unstable;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        we0;
        logic [31:0] rd;
        @(negedge clk);
        cur_lat    = lat;
        memreadM   = (op & 1) != 0;
        memwriteM  = (op & 2) != 0;
        aluresultM = addr;
        writedataM = wdata;
        sbq.push_back('{name, exp_data, exp_stall, op == 1, exp_stall > 0,
                        {addr[31:2], 2'b00}, op >= 2, wdata});
        stalls = 0; done = 0; seen = 0; unstable = 0;
        a0 = '0; d0 = '0; we0 = 1'b0; rd = '0;
        for (int c = 0; c < 50 && !done; c++) begin
            #2;
            if (mem_req) begin
                if (!seen) begin
                    seen = 1; a0 = mem_addr; we0 = mem_we; d0 = mem_wdata;
                end else if (a0 !== mem_addr || we0 !== mem_we || d0 !== mem_wdata) begin
                    unstable = 1;
                end
            end
            if (!stallM) begin
                done = 1;
                rd   = readdataM;
                if (flush_rdy) flush = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            flush = 1'b0;
            if (!done) @(negedge clk);
        end
        memreadM  = 1'b0;
        memwriteM = 1'b0;
        e = sbq.pop_front();
        check({e.name, " completes"}, 64'(done), 64'(1));
        check({e.name, " stall cycles"}, 64'(stalls), 64'(e.stalls));
        if (e.chk_data) check({e.name, " readdata"}, 64'(rd), 64'(e.data));
        check({e.name, " mem_req seen"}, 64'(seen), 64'(e.exp_req));
        if (e.exp_req) begin
            check({e.name, " mem_addr"}, 64'(a0), 64'(e.addr));
            check({e.name, " mem_we"}, 64'(we0), 64'(e.we));
            check({e.name, " req stable"}, 64'(unstable), 64'(0));
            if (e.we) check({e.name, " mem_wdata"}, 64'(d0), 64'(e.wdata));
        end
    endtask

    typedef struct {
        string       name;
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_data;
        int          exp_stall;
    } vec_t;

    vec_t vecs[13];

    task automatic check_quiet(input string tag);
        check({tag, " stallM"}, 64'(stallM), 64'(0));
        check({tag, " readdataM"}, 64'(readdataM), 64'(0));
        check({tag, " mem_req"}, 64'(mem_req), 64'(0));
        check({tag, " mem_we"}, 64'(mem_we), 64'(0));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, " hit_count"}, 64'(hit_count), 64'(0));
        check({tag, " miss_count"}, 64'(miss_count), 64'(0));
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        cur_lat = 1;
        memreadM = 0; memwriteM = 0; aluresultM = '0; writedataM = '0; flush = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_quiet("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // index = addr[4:2]; 0x100/0x120/0x200 share index 0
        vecs[0]  = '{"cold_ld",   1, 32'h100, 32'h0,        3, 32'hDEADBEEF, 3};
        vecs[1]  = '{"hit_ld",    1, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0};
        vecs[2]  = '{"st_hit",    2, 32'h100, 32'h12345678, 1, 32'h0,        1};
        vecs[3]  = '{"ld_after_st", 1, 32'h100, 32'h0,      1, 32'h12345678, 0};
        vecs[4]  = '{"conflict",  1, 32'h120, 32'h0,        2, 32'hCAFEF00D, 2};
        vecs[5]  = '{"evicted",   1, 32'h100, 32'h0,        1, 32'h12345678, 1};
        vecs[6]  = '{"evicted2",  1, 32'h120, 32'h0,        1, 32'hCAFEF00D, 1};
        vecs[7]  = '{"st_miss",   2, 32'h144, 32'h55AA55AA, 2, 32'h0,        2};
        vecs[8]  = '{"no_alloc",  1, 32'h146, 32'h0,        1, 32'h55AA55AA, 1};
        vecs[9]  = '{"hit_ld2",   1, 32'h144, 32'h0,        1, 32'h55AA55AA, 0};
        vecs[10] = '{"rd_wr_st",  3, 32'h144, 32'h0F0F0F0F, 1, 32'h0,        1};
        vecs[11] = '{"hit_ld3",   1, 32'h147, 32'h0,        1, 32'h0F0F0F0F, 0};
        vecs[12] = '{"slow_miss", 1, 32'h3FC, 32'h0,        4, 32'hC00000FF, 4};

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
                   vecs[i].exp_data, vecs[i].exp_stall, 1'b0);
        check("table hit_count", 64'(hit_count), 64'(4));
        check("table miss_count", 64'(miss_count), 64'(6));

        // No request: valid line under the address must not leak out
        @(negedge clk);
        aluresultM = 32'h144;
        #2;
        check("idle stallM", 64'(stallM), 64'(0));
        check("idle readdataM", 64'(readdataM), 64'(0));

        // Flush pulse invalidates everything
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        run_op("flush_ld", 1, 32'h144, 32'h0, 1, 32'h0F0F0F0F, 1, 1'b0);

        // Flush coincident with a fill: only the filled line survives
        run_op("fill_flush", 1, 32'h200, 32'h0, 2, 32'hC0000080, 2, 1'b1);
        run_op("fill_kept",  1, 32'h200, 32'h0, 1, 32'hC0000080, 0, 1'b0);
        run_op("other_gone", 1, 32'h144, 32'h0, 1, 32'h0F0F0F0F, 1, 1'b0);
        check("flush hit_count", 64'(hit_count), 64'(5));
        check("flush miss_count", 64'(miss_count), 64'(9));

        // Reset in the middle of a read miss
        @(negedge clk);
        cur_lat    = 10;
        memreadM   = 1'b1;
        aluresultM = 32'h100;
        @(posedge clk);
        #3 check("rst pre mem_req", 64'(mem_req), 64'(1));
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_quiet("mid rst");
        @(negedge clk);
        rst      = 1'b1;
        memreadM = 1'b0;
        run_op("post_rst_ld", 1, 32'h100, 32'h0, 1, 32'h12345678, 1, 1'b0);
        check("post rst miss_count", 64'(miss_count), 64'(1));

        // Hit counter saturation
        @(negedge clk);
        memreadM   = 1'b1;
        aluresultM = 32'h100;
        #2;
        check("sat stallM", 64'(stallM), 64'(0));
        check("sat readdata", 64'(readdataM), 64'(32'h12345678));
        repeat (70000) @(posedge clk);
        #1 memreadM = 1'b0;
        check("sat hit_count", 64'(hit_count), 64'(16'hFFFF));
        check("sat miss_count", 64'(miss_count), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
